mod_inv_fermat: RTL and testbench
=================================

Name: mod_inv_fermat

Overview:
- Modular inverse engine for the NTT datapath: computes a^-1 mod Q as a^(Q-2) (Fermat) by left-to-right square-and-multiply.
- Acts as the initiator toward the existing pipelined modular multiplier: it drives operand pairs and collects products after a fixed latency.
- Used for scale-factor and twiddle precomputation; both sides use valid/ready handshakes.

Parameters:
- DATA_WIDTH, 12, operand/result width.
- Q, 3329, modulus.
- MUL_LAT, 4, cycles from operand presentation to valid product on mul_p.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-low.
- in_valid  in  1  operand offered.
- in_ready  out  1  high only in IDLE.
- a_in  in  DATA_WIDTH  operand.
- out_valid  out  1  result held until accepted.
- out_ready  in  1  downstream accept.
- inv_out  out  DATA_WIDTH  a^-1 mod Q.
- err_out  out  1  qualifies inv_out; set for a_in==0 or a_in>=Q.
- mul_a  out  DATA_WIDTH  multiplier operand A.
- mul_b  out  DATA_WIDTH  multiplier operand B.
- mul_p  in  DATA_WIDTH  multiplier product, valid MUL_LAT cycles after issue.

Behaviour:
- Reset (rst==0 at posedge): state=IDLE. All outputs are 0 except in_ready=1. Any run in progress is abandoned, and late mul_p values are ignored.
- Exponent E=Q-2=3327=0xCFF. The MSB is known to be 1, so r:=a on accept. Bits 10..0 are then processed MSB-first.
  - Each bit: square (r:=r*r); then, if the bit is 1, multiply (r:=r*a).
  - Total: 11 squares + 9 multiplies = 20 multiplier ops.
- States and transitions:
  - IDLE: on in_valid, latch a.
    - If a==0 or a>=Q: go to DONE with inv_out=0, err_out=1.
    - Otherwise: r=a, bit index=10, go to SQR.
  - SQR: drive mul_a=mul_b=r for exactly 1 cycle, then go to SQR_WAIT.
  - SQR_WAIT: counter counts MUL_LAT-1 cycles. On the edge ending the MUL_LAT-th cycle after issue, capture r:=mul_p. Then go to MUL if E[idx]==1, else to NEXT.
  - MUL: drive mul_a=r, mul_b=a for 1 cycle, then go to MUL_WAIT (same timing rule as SQR_WAIT), then to NEXT.
  - NEXT: if idx==0, go to DONE. Otherwise decrement idx and go to SQR. NEXT is a zero-cycle decision folded into the capture edge; it is not a separate cycle.
  - DONE: out_valid=1 with inv_out=r and err_out=0. Hold until out_ready, then go to IDLE. Outputs clear on the accepting edge.
- Outside issue cycles, mul_a and mul_b are driven to 0.
- Latency: out_valid rises exactly 20*(MUL_LAT+1)+1 cycles after the in_valid&&in_ready edge. The error path takes 1 cycle.
- Only one operation is in flight; in_ready stays low from accept until DONE handshake completes.
- in_valid while busy is ignored, not queued.
- out_ready while out_valid is low has no effect.
- inv_out is always < Q, because the multiplier reduces fully.

Optional Feature:
- Macro MOD_INV_SELFCHECK_EN.
- When defined: after the final capture, issue one extra op with mul_a=r, mul_b=a. The result is compared to 1, and the port chk_fail_out (1 bit, sampled with out_valid) is set if the product != 1. Latency grows by MUL_LAT+1 cycles.
- When undefined: the port is absent and the latency is as stated above.

Decomposition:
- Package mod_arith_pkg holds:
  - Q and DATA_WIDTH defaults;
  - the constant INV_EXP=Q-2 and its bit length;
  - the state enum (IDLE, SQR, SQR_WAIT, MUL, MUL_WAIT, DONE).
- One sub-module, mul_lat_timer: a loadable down-counter that pulses "product valid" MUL_LAT cycles after issue. It is shared with other multiplier initiators.
- The multiplier itself stays external so it can be time-shared.

Test Plan (bench instantiates modular_mul behind this block; MUL_LAT matches the multiplier pipeline):
- a_in=1 → inv_out=1, err_out=0, out_valid exactly 20*(MUL_LAT+1)+1 cycles after accept.
- a_in=2 → 1665; a_in=17 → 1175; a_in=3328 → 3328. Issue these back-to-back, with in_ready checked low throughout each run.
- a_in=0 and a_in=3329 → each gives err_out=1, inv_out=0, 1-cycle latency.
- Hold out_ready=0 for 10 cycles in DONE → out_valid and inv_out stable, in_ready=0. Then raise out_ready → IDLE next cycle.
- Deassert rst mid-run (during 5th MUL_WAIT) → next cycle all outputs 0 and in_ready=1. A fresh a_in=2 then returns 1665, unaffected by stale products.
- With MOD_INV_SELFCHECK_EN: random sweep of 200 values in 1..3328 → chk_fail_out=0 and inv_out*a_in mod 3329 ==1 for every value.

Source files
------------

// File: rtl/mod_arith_pkg.sv
// mod_arith_pkg: shared modular-arithmetic constants and the inverse-engine state type.
`default_nettype none

package mod_arith_pkg;

   localparam int DEF_DATA_WIDTH = 12;
   localparam int DEF_Q          = 3329;

   // Fermat exponent Q-2; its MSB is always 1, so the engine starts with r = a.
   localparam int                        INV_EXP_BITS = $clog2(DEF_Q - 1);
   localparam logic [INV_EXP_BITS-1:0]   INV_EXP      = INV_EXP_BITS'(DEF_Q - 2);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      SQR      = 3'd1,
      SQR_WAIT = 3'd2,
      MUL      = 3'd3,
      MUL_WAIT = 3'd4,
      DONE     = 3'd5
   } state_t;

endpackage

`default_nettype wire

// File: rtl/mod_inv_fermat_if.sv
// mod_inv_fermat_if: request/response handshake plus the external multiplier port pair.
`default_nettype none

interface mod_inv_fermat_if
   import mod_arith_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_WIDTH-1:0] a_in;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] inv_out;
   logic                  err_out;
   logic [DATA_WIDTH-1:0] mul_a;
   logic [DATA_WIDTH-1:0] mul_b;
   logic [DATA_WIDTH-1:0] mul_p;
`ifdef MOD_INV_SELFCHECK_EN
   logic                  chk_fail_out;
`endif

   modport slave (
`ifdef MOD_INV_SELFCHECK_EN
      output chk_fail_out,
`endif
      input  in_valid, a_in, out_ready, mul_p,
      output in_ready, out_valid, inv_out, err_out, mul_a, mul_b
   );

   modport master (
`ifdef MOD_INV_SELFCHECK_EN
      input  chk_fail_out,
`endif
      output in_valid, a_in, out_ready, mul_p,
      input  in_ready, out_valid, inv_out, err_out, mul_a, mul_b
   );

endinterface

`default_nettype wire

// File: rtl/mul_lat_timer.sv
// mul_lat_timer: loadable down-counter; o_done is high in the LAT-th cycle after the load cycle.
`default_nettype none

module mul_lat_timer #(
   parameter int LAT = 4
) (
   input  wire logic clk,
   input  wire logic rst,
   input  wire logic i_load,
   output logic      o_done
);
   localparam int c_CNT_W = (LAT > 1) ? $clog2(LAT) : 1;

   logic [c_CNT_W-1:0] r_cnt;
   logic               r_busy;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_cnt  <= '0;
         r_busy <= 1'b0;
      end else if (i_load) begin
         r_cnt  <= c_CNT_W'(LAT - 1);
         r_busy <= 1'b1;
      end else if (r_busy) begin
         if (r_cnt == '0) r_busy <= 1'b0;
         else             r_cnt  <= r_cnt - c_CNT_W'(1);
      end
   end

   assign o_done = r_busy && (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/mod_inv_fermat.sv
// mod_inv_fermat: a^-1 mod Q as a^(Q-2) by square-and-multiply on an external pipelined multiplier.
// Optional MOD_INV_SELFCHECK_EN adds a final r*a==1 check reported on chk_fail_out.
`default_nettype none

module mod_inv_fermat
   import mod_arith_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int Q          = DEF_Q,
   parameter int MUL_LAT    = 4
) (
   input  wire logic        clk,
   input  wire logic        rst,
   mod_inv_fermat_if.slave  bus
);
   localparam int                    c_IDX_W = $clog2(INV_EXP_BITS);
   localparam logic [DATA_WIDTH-1:0] c_Q     = DATA_WIDTH'(Q);
   localparam logic [DATA_WIDTH-1:0] c_ONE   = DATA_WIDTH'(1);

   state_t                r_state, w_state_nxt, w_step_state;
   logic [DATA_WIDTH-1:0] r_a, w_a_nxt;
   logic [DATA_WIDTH-1:0] r_r, w_r_nxt;
   logic [c_IDX_W-1:0]    r_idx, w_idx_nxt, w_step_idx;
   logic                  r_err, w_err_nxt;
   logic                  r_out_valid, w_ov_nxt;
   logic                  w_load, w_done;
   logic [DATA_WIDTH-1:0] w_mul_a, w_mul_b;
`ifdef MOD_INV_SELFCHECK_EN
   logic                  r_chk, w_chk_nxt, w_step_chk;
   logic                  r_chk_fail, w_chk_fail_nxt;
`endif

   mul_lat_timer #(.LAT(MUL_LAT)) u_timer (
      .clk    (clk),
      .rst    (rst),
      .i_load (w_load),
      .o_done (w_done)
   );

   // Where to go after a capture that completes the current exponent bit.
   always_comb begin
      w_step_idx = r_idx - c_IDX_W'(1);
`ifdef MOD_INV_SELFCHECK_EN
      w_step_chk = 1'b0;
`endif
      if (r_idx == '0) begin
         w_step_idx = r_idx;
`ifdef MOD_INV_SELFCHECK_EN
         w_step_state = MUL;
         w_step_chk   = 1'b1;
`else
         w_step_state = DONE;
`endif
      end else begin
         w_step_state = SQR;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_a_nxt     = r_a;
      w_r_nxt     = r_r;
      w_idx_nxt   = r_idx;
      w_err_nxt   = r_err;
      w_ov_nxt    = r_out_valid;
      w_load      = 1'b0;
      w_mul_a     = '0;
      w_mul_b     = '0;
`ifdef MOD_INV_SELFCHECK_EN
      w_chk_nxt      = r_chk;
      w_chk_fail_nxt = r_chk_fail;
`endif
      case (r_state)
         IDLE: begin
            if (bus.in_valid) begin
               w_a_nxt = bus.a_in;
`ifdef MOD_INV_SELFCHECK_EN
               w_chk_nxt      = 1'b0;
               w_chk_fail_nxt = 1'b0;
`endif
               if ((bus.a_in == '0) || (bus.a_in >= c_Q)) begin
                  w_r_nxt     = '0;
                  w_err_nxt   = 1'b1;
                  w_state_nxt = DONE;
               end else begin
                  w_r_nxt     = bus.a_in;
                  w_err_nxt   = 1'b0;
                  w_idx_nxt   = c_IDX_W'(INV_EXP_BITS - 2);
                  w_state_nxt = SQR;
               end
            end
         end
         SQR: begin
            w_mul_a     = r_r;
            w_mul_b     = r_r;
            w_load      = 1'b1;
            w_state_nxt = SQR_WAIT;
         end
         SQR_WAIT: begin
            if (w_done) begin
               w_r_nxt = bus.mul_p;
               if (INV_EXP[r_idx]) begin
                  w_state_nxt = MUL;
               end else begin
                  w_state_nxt = w_step_state;
                  w_idx_nxt   = w_step_idx;
`ifdef MOD_INV_SELFCHECK_EN
                  w_chk_nxt   = w_step_chk;
`endif
               end
            end
         end
         MUL: begin
            w_mul_a     = r_r;
            w_mul_b     = r_a;
            w_load      = 1'b1;
            w_state_nxt = MUL_WAIT;
         end
         MUL_WAIT: begin
            if (w_done) begin
`ifdef MOD_INV_SELFCHECK_EN
               if (r_chk) begin
                  w_chk_fail_nxt = (bus.mul_p != c_ONE);
                  w_chk_nxt      = 1'b0;
                  w_state_nxt    = DONE;
               end else begin
                  w_r_nxt     = bus.mul_p;
                  w_state_nxt = w_step_state;
                  w_idx_nxt   = w_step_idx;
                  w_chk_nxt   = w_step_chk;
               end
`else
               w_r_nxt     = bus.mul_p;
               w_state_nxt = w_step_state;
               w_idx_nxt   = w_step_idx;
`endif
            end
         end
         DONE: begin
            // First DONE cycle raises out_valid; the handshake then returns to IDLE.
            if (!r_out_valid) begin
               w_ov_nxt = 1'b1;
            end else if (bus.out_ready) begin
               w_ov_nxt    = 1'b0;
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state     <= IDLE;
         r_a         <= '0;
         r_r         <= '0;
         r_idx       <= '0;
         r_err       <= 1'b0;
         r_out_valid <= 1'b0;
`ifdef MOD_INV_SELFCHECK_EN
         r_chk       <= 1'b0;
         r_chk_fail  <= 1'b0;
`endif
      end else begin
         r_state     <= w_state_nxt;
         r_a         <= w_a_nxt;
         r_r         <= w_r_nxt;
         r_idx       <= w_idx_nxt;
         r_err       <= w_err_nxt;
         r_out_valid <= w_ov_nxt;
`ifdef MOD_INV_SELFCHECK_EN
         r_chk       <= w_chk_nxt;
         r_chk_fail  <= w_chk_fail_nxt;
`endif
      end
   end

   assign bus.in_ready  = (r_state == IDLE);
   assign bus.out_valid = r_out_valid;
   assign bus.inv_out   = r_out_valid ? r_r : '0;
   assign bus.err_out   = r_out_valid & r_err;
   assign bus.mul_a     = w_mul_a;
   assign bus.mul_b     = w_mul_b;
`ifdef MOD_INV_SELFCHECK_EN
   assign bus.chk_fail_out = r_out_valid & r_chk_fail;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mod_inv_fermat.sv
// tb_mod_inv_fermat: directed and random checks of mod_inv_fermat against a brute-force inverse model.
`default_nettype none

module tb_mod_inv_fermat;
   localparam int DW      = 12;
   localparam int QM      = 3329;
   localparam int MUL_LAT = 4;
`ifdef MOD_INV_SELFCHECK_EN
   localparam int EXP_LAT = 21 * (MUL_LAT + 1) + 1;
   localparam int N_RAND  = 200;
`else
   localparam int EXP_LAT = 20 * (MUL_LAT + 1) + 1;
   localparam int N_RAND  = 40;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   mod_inv_fermat_if #(.DATA_WIDTH(DW)) bus ();

   mod_inv_fermat #(.DATA_WIDTH(DW), .Q(QM), .MUL_LAT(MUL_LAT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Pipelined modular multiplier: product appears MUL_LAT cycles after issue.
   logic [DW-1:0] pipe [MUL_LAT];
   always @(posedge clk) begin
      pipe[0] <= DW'((int'(bus.mul_a) * int'(bus.mul_b)) % QM);
      for (int i = 1; i < MUL_LAT; i++) pipe[i] <= pipe[i-1];
   end
   assign bus.mul_p = pipe[MUL_LAT-1];

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int ref_inv(input int a);
      if (a == 0 || a >= QM) return 0;
      for (int x = 1; x < QM; x++)
         if ((a * x) % QM == 1) return x;
      return -1;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start(input int a);
      int n = 0;
      while (!bus.in_ready && n < 500) begin
         tick();
         n++;
      end
      check($sformatf("in_ready_before_a%0d", a), int'(bus.in_ready), 1);
      bus.a_in     = DW'(a);
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      bus.a_in     = DW'($urandom);
   endtask

   task automatic wait_result(output int lat, output int busy_bad);
      lat      = 0;
      busy_bad = 0;
      while (!bus.out_valid && lat < 2000) begin
         if (bus.in_ready) busy_bad++;
         // A request while busy must be ignored.
         bus.in_valid = (lat == 7);
         bus.a_in     = DW'(5);
         tick();
         lat++;
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic accept(input int a);
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      check($sformatf("out_valid_after_accept_a%0d", a), int'(bus.out_valid), 0);
      check($sformatf("in_ready_after_accept_a%0d", a), int'(bus.in_ready), 1);
   endtask

   task automatic check_result(input int a, input int lat, input int busy_bad);
      bit bad_in = (a == 0 || a >= QM);
      check($sformatf("latency_a%0d", a), lat, bad_in ? 1 : EXP_LAT);
      check($sformatf("inv_a%0d", a), int'(bus.inv_out), ref_inv(a));
      check($sformatf("err_a%0d", a), int'(bus.err_out), int'(bad_in));
      check($sformatf("busy_in_ready_a%0d", a), busy_bad + int'(bus.in_ready), 0);
      if (!bad_in)
         check($sformatf("inv_times_a%0d", a), (int'(bus.inv_out) * a) % QM, 1);
`ifdef MOD_INV_SELFCHECK_EN
      check($sformatf("chk_fail_a%0d", a), int'(bus.chk_fail_out), 0);
`endif
   endtask

   task automatic run_op(input int a);
      int lat, busy_bad;
      start(a);
      wait_result(lat, busy_bad);
      check_result(a, lat, busy_bad);
      accept(a);
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_in_ready"}, int'(bus.in_ready), 1);
      check({tag, "_out_valid"}, int'(bus.out_valid), 0);
      check({tag, "_inv_out"}, int'(bus.inv_out), 0);
      check({tag, "_err_out"}, int'(bus.err_out), 0);
      check({tag, "_mul_ab"}, int'(bus.mul_a) + int'(bus.mul_b), 0);
   endtask

   initial begin
      int lat, busy_bad, unstable;
      bus.in_valid  = 1'b0;
      bus.a_in      = '0;
      bus.out_ready = 1'b0;

      // Reset state
      rst = 1'b0;
      repeat (3) tick();
      check_idle_outputs("reset");
      rst = 1'b1;
      tick();

      // out_ready with nothing pending has no effect
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      check_idle_outputs("idle_out_ready");

      // Directed values, back-to-back, then the error inputs
      run_op(1);
      run_op(2);
      run_op(17);
      run_op(3328);
      run_op(0);
      run_op(3329);

      // Result held under back-pressure
      start(17);
      wait_result(lat, busy_bad);
      check_result(17, lat, busy_bad);
      unstable = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (bus.out_valid !== 1'b1 || int'(bus.inv_out) != 1175 || bus.in_ready !== 1'b0)
            unstable++;
      end
      check("hold_stable", unstable, 0);
      accept(17);

      // Reset during the 5th multiply wait (op 12 issues after edge 55)
      start(2);
      repeat (11 * (MUL_LAT + 1) + 2) tick();
      rst = 1'b0;
      tick();
      check_idle_outputs("midrun_reset");
      rst = 1'b1;
      tick();
      run_op(2);

      // Random sweep
      for (int k = 0; k < N_RAND; k++)
         run_op(int'($urandom_range(1, QM - 1)));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
